// File: rtl/fold_sample_scheduler.sv
// fold_sample_scheduler
// Buffers upstream samples in a small FIFO and issues one of them per
// FOLD-cycle slot to a folded IIR. If the FIFO is empty when a slot is due,
// a bubble (zero) is issued instead. Each slot's real/bubble flag travels
// alongside the filter latency, so y_valid marks only results that came from
// real samples.
module fold_sample_scheduler #(
  parameter int W         = 8,
  parameter int FOLD      = 4,
  parameter int DEPTH     = 4,
  parameter int LAT_SLOTS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [W-1:0]             s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [W-1:0]             x_fold,
  input  logic [W-1:0]             y_fold,
  output logic [W-1:0]             y_out,
  output logic                     y_valid,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [7:0]               underrun_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (FOLD > 1) ? $clog2(FOLD) : 1;

  logic [PW-1:0]        phase;
  logic [W-1:0]         mem [DEPTH];
  logic [AW-1:0]        rd_ptr;
  logic [AW-1:0]        wr_ptr;
  logic [CW-1:0]        count;
  logic [LAT_SLOTS-1:0] slot_flags;

  logic full;
  logic empty;
  logic issue;
  logic push;
  logic pop;

  // Handshake and slot decode, all from registered state. A push while full
  // is refused even if the same edge pops, which keeps the full path free of
  // any combinational dependence on the issue timing.
  always_comb begin
    full    = (count == CW'(DEPTH));
    empty   = (count == '0);
    issue   = (phase == PW'(FOLD - 1));
    s_ready = rst | ~full;
    push    = s_valid & ~full & ~rst;
    pop     = issue & ~empty;
  end

  assign fill = count;

  // Slot phase counter: 0..FOLD-1, issue happens on the FOLD-1 edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
    end else if (issue) begin
      phase <= '0;
    end else begin
      phase <= phase + PW'(1);
    end
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  // FIFO pointers and occupancy. Pointers wrap naturally since DEPTH is a
  // power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue register: the FIFO head for one cycle on a real slot, zero otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_fold <= '0;
    end else if (pop) begin
      x_fold <= mem[rd_ptr];
    end else begin
      x_fold <= '0;
    end
  end

  // Bubble counter, saturating so a long stall cannot wrap back to a small value.
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_cnt <= '0;
    end else if (issue && empty && (underrun_cnt != 8'hFF)) begin
      underrun_cnt <= underrun_cnt + 8'd1;
    end
  end

  // Result capture: sample y_fold once per slot and qualify it with the flag
  // of the slot issued LAT_SLOTS slots earlier.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_out      <= '0;
      y_valid    <= 1'b0;
      slot_flags <= '0;
    end else if (issue) begin
      y_out         <= y_fold;
      y_valid       <= slot_flags[LAT_SLOTS-1];
      slot_flags[0] <= ~empty;
      for (int i = 1; i < LAT_SLOTS; i++) begin
        slot_flags[i] <= slot_flags[i-1];
      end
    end else begin
      y_valid <= 1'b0;
    end
  end

endmodule
